// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - ID-stage hazard/stall bus between pipeline and stall controller
interface hazard_stall_controller_if #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   idex_mem_read;
   logic [REG_ADDR_W-1:0]  idex_rt;
   logic [REG_ADDR_W-1:0]  ifid_rs;
   logic [REG_ADDR_W-1:0]  ifid_rt;
   logic                   ifid_uses_rs;
   logic                   ifid_uses_rt;
   logic                   branch_taken;
   logic                   dmem_wait;
   logic                   stall_cnt_clr;

   logic                   pc_write;
   logic                   ifid_write;
   logic                   ctrl_en;
   logic                   ifid_flush;
   logic                   pipe_hold;
   logic                   stall_active;
   logic [STALL_CNT_W-1:0] stall_cnt;

   // Pipeline side: presents ID-stage operand info, consumes the enables
   modport master (
      output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
             branch_taken, dmem_wait, stall_cnt_clr,
      input  pc_write, ifid_write, ctrl_en, ifid_flush, pipe_hold, stall_active, stall_cnt
   );

   modport slave (
      input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
             branch_taken, dmem_wait, stall_cnt_clr,
      output pc_write, ifid_write, ctrl_en, ifid_flush, pipe_hold, stall_active, stall_cnt
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use stall / branch flush / dmem freeze controller
module hazard_stall_controller #(
   parameter int REG_ADDR_W        = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int ZERO_REG_EXEMPT   = 1,
   parameter int STALL_CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   hazard_stall_controller_if.slave  bus
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } state_t;

   localparam logic [3:0]             C_BUB_LOAD = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic                   C_MULTI    = (LOAD_STALL_CYCLES > 1);
   localparam logic                   C_EXEMPT   = (ZERO_REG_EXEMPT != 0);
   localparam logic [STALL_CNT_W-1:0] C_CNT_MAX  = '1;

   state_t                 r_state;
   logic [3:0]             r_bub_cnt;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic [REG_ADDR_W-1:0]  w_idex_rt;
   logic [REG_ADDR_W-1:0]  w_ifid_rs;
   logic [REG_ADDR_W-1:0]  w_ifid_rt;
   logic                   w_match_rs;
   logic                   w_match_rt;
   logic                   w_hz;
   logic                   w_pc_write;
   logic                   w_ifid_write;
   logic                   w_ctrl_en;
   logic                   w_ifid_flush;
   logic                   w_pipe_hold;
   logic                   w_stall_active;

   assign w_idex_rt = bus.idex_rt;
   assign w_ifid_rs = bus.ifid_rs;
   assign w_ifid_rt = bus.ifid_rt;

   // Register 0 is hard-wired zero, so a load "to" it never produces a real dependency
   assign w_match_rs = bus.ifid_uses_rs && (w_idex_rt == w_ifid_rs)
                       && !(C_EXEMPT && (w_ifid_rs == '0));
   assign w_match_rt = bus.ifid_uses_rt && (w_idex_rt == w_ifid_rt)
                       && !(C_EXEMPT && (w_ifid_rt == '0));
   assign w_hz       = bus.idex_mem_read && (w_match_rs || w_match_rt);

   always_comb begin
      w_pc_write     = 1'b1;
      w_ifid_write   = 1'b1;
      w_ctrl_en      = 1'b1;
      w_ifid_flush   = 1'b0;
      w_pipe_hold    = 1'b0;
      w_stall_active = 1'b0;
      if (!rst) begin
         w_stall_active = (r_state == LU_STALL);
         if (bus.dmem_wait) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_hold  = 1'b1;
         end else if ((r_state == LU_STALL) || w_hz) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ctrl_en    = 1'b0;
         end else if (bus.branch_taken) begin
            w_ifid_flush = 1'b1;
         end
      end
   end

   // The first bubble is issued combinationally from RUN; LU_STALL covers the remaining ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RUN;
         r_bub_cnt <= 4'd0;
      end else if (!bus.dmem_wait) begin
         case (r_state)
            RUN: begin
               if (w_hz && C_MULTI) begin
                  r_state   <= LU_STALL;
                  r_bub_cnt <= C_BUB_LOAD;
               end
            end
            LU_STALL: begin
               if (r_bub_cnt == 4'd1) begin
                  r_state   <= RUN;
                  r_bub_cnt <= 4'd0;
               end else begin
                  r_bub_cnt <= r_bub_cnt - 4'd1;
               end
            end
            default: begin
               r_state   <= RUN;
               r_bub_cnt <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (bus.stall_cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (!w_pc_write && (r_stall_cnt != C_CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.pc_write     = w_pc_write;
   assign bus.ifid_write   = w_ifid_write;
   assign bus.ctrl_en      = w_ctrl_en;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.pipe_hold    = w_pipe_hold;
   assign bus.stall_active = w_stall_active;
   assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

   localparam logic [5:0] PASS = 6'b111000;
   localparam logic [5:0] STL  = 6'b000000;
   localparam logic [5:0] LUS  = 6'b000001;
   localparam logic [5:0] FLS  = 6'b111100;
   localparam logic [5:0] HLD  = 6'b001010;
   localparam logic [5:0] HLU  = 6'b001011;

   typedef struct {
      logic [5:0] v;
      int         cnt;
      string      tag;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t q_a[$];
   exp_t q_b[$];

   hazard_stall_controller_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) if_a ();
   hazard_stall_controller_if #(.REG_ADDR_W(5), .STALL_CNT_W(4))  if_b ();

   hazard_stall_controller #(
      .REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .ZERO_REG_EXEMPT(1), .STALL_CNT_W(16)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   hazard_stall_controller #(
      .REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .ZERO_REG_EXEMPT(1), .STALL_CNT_W(4)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string dut, input logic [5:0] act_v, input int act_c, input exp_t e);
      checks++;
      if (act_v !== e.v || act_c != e.cnt) begin
         failures++;
         $display("FAIL %s %s: outputs=%b stall_cnt=%0d, required outputs=%b stall_cnt=%0d",
                  dut, e.tag, act_v, act_c, e.v, e.cnt);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the active edge
   always @(negedge clk) begin : monitor
      exp_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         compare("A", {if_a.pc_write, if_a.ifid_write, if_a.ctrl_en, if_a.ifid_flush,
                       if_a.pipe_hold, if_a.stall_active}, int'(if_a.stall_cnt), e);
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         compare("B", {if_b.pc_write, if_b.ifid_write, if_b.ctrl_en, if_b.ifid_flush,
                       if_b.pipe_hold, if_b.stall_active}, int'(if_b.stall_cnt), e);
      end
   end

   task automatic step(input int sel, input logic r, input logic mr, input logic [4:0] lrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic br, input logic w, input logic clr,
                       input logic [5:0] ev, input int ec, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      if_a.idex_mem_read = mr;  if_b.idex_mem_read = mr;
      if_a.idex_rt       = lrt; if_b.idex_rt       = lrt;
      if_a.ifid_rs       = rs;  if_b.ifid_rs       = rs;
      if_a.ifid_rt       = rt;  if_b.ifid_rt       = rt;
      if_a.ifid_uses_rs  = urs; if_b.ifid_uses_rs  = urs;
      if_a.ifid_uses_rt  = urt; if_b.ifid_uses_rt  = urt;
      if_a.branch_taken  = br;  if_b.branch_taken  = br;
      if_a.dmem_wait     = w;   if_b.dmem_wait     = w;
      if_a.stall_cnt_clr = clr; if_b.stall_cnt_clr = clr;
      e.v   = ev;
      e.cnt = ec;
      e.tag = tag;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
   endtask

   initial begin
      int wait_cyc;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      if_a.idex_mem_read = 0; if_b.idex_mem_read = 0;
      if_a.idex_rt = 0; if_b.idex_rt = 0; if_a.ifid_rs = 0; if_b.ifid_rs = 0;
      if_a.ifid_rt = 0; if_b.ifid_rt = 0;
      if_a.ifid_uses_rs = 0; if_b.ifid_uses_rs = 0; if_a.ifid_uses_rt = 0; if_b.ifid_uses_rt = 0;
      if_a.branch_taken = 0; if_b.branch_taken = 0; if_a.dmem_wait = 0; if_b.dmem_wait = 0;
      if_a.stall_cnt_clr = 0; if_b.stall_cnt_clr = 0;

      // DUT A: single-bubble configuration
      step(0, 1, 1, 8, 8, 0, 1, 0, 1, 0, 0, PASS, 0, "reset_forces_pass");
      step(0, 0, 1, 8, 8, 0, 1, 0, 0, 0, 0, STL,  0, "lu1_hazard_rs");
      step(0, 0, 0, 8, 8, 0, 1, 0, 0, 0, 0, PASS, 1, "lu1_resume");
      step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, PASS, 1, "r0_exempt");
      step(0, 0, 1, 9, 3, 9, 1, 0, 0, 0, 0, PASS, 1, "rt_unused");
      step(0, 0, 1, 9, 3, 9, 1, 1, 0, 0, 0, STL,  1, "lu1_hazard_rt");
      step(0, 0, 0, 8, 8, 0, 1, 0, 1, 0, 0, FLS,  2, "branch_flush");
      step(0, 0, 1, 8, 8, 0, 1, 0, 1, 0, 0, STL,  2, "branch_vs_hazard");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 3, "idle");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, PASS, 3, "clr_issue");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 0, "clr_done");

      // DUT B: three-bubble configuration, 4-bit counter
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 0, "b_reset");
      step(1, 0, 1, 8, 8, 0, 1, 0, 0, 0, 0, STL,  0, "lu3_c1");
      step(1, 0, 0, 8, 8, 0, 1, 0, 1, 0, 0, LUS,  1, "lu3_c2_br_ignored");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUS,  2, "lu3_c3");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 3, "lu3_done");

      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 0, "b_reset2");
      step(1, 0, 1, 8, 8, 0, 1, 0, 0, 0, 0, STL,  0, "dw_c1");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLU,  1, "dw_wait1");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLU,  2, "dw_wait2");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUS,  3, "dw_c2");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUS,  4, "dw_c3");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 5, "dw_done");
      step(1, 0, 1, 8, 8, 0, 1, 0, 0, 1, 0, HLD,  5, "dw_over_hz");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 6, "dw_hz_ignored");

      step(1, 0, 1, 8, 8, 0, 1, 0, 0, 0, 0, STL,  6, "ar_c1");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUS,  7, "ar_c2");
      step(1, 1, 1, 8, 8, 0, 1, 0, 0, 0, 0, PASS, 0, "ar_async_reset");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 0, "ar_bubbles_dropped");

      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLD, (i < 15) ? i : 15, "sat_ramp");
      end
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 15, "sat_hold");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, HLD,  15, "clr_vs_inc");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PASS, 0,  "clr_wins");

      wait_cyc = 0;
      while ((q_a.size() > 0 || q_b.size() > 0) && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      checks++;
      if (q_a.size() > 0 || q_b.size() > 0) begin
         failures++;
         $display("FAIL drain: pending=%0d required=0", q_a.size() + q_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
